// File: rtl/rr_arb4x16_if.sv
// Handshake bundle for the 4-way round-robin arbiter: four requester lanes in,
// one registered word out.
interface rr_arb4x16_if;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_arb4x16.sv
// Round-robin arbiter sharing one 16-bit datapath among four requesters, with
// optional burst lock and a registered valid/ready output stage.
module mux4way16 (
    input  logic [63:0] in_data,
    input  logic [1:0]  sel,
    output logic [15:0] out
);
    // Word select by requester index.
    always_comb begin
        case (sel)
            2'd0:    out = in_data[15:0];
            2'd1:    out = in_data[31:16];
            2'd2:    out = in_data[47:32];
            2'd3:    out = in_data[63:48];
            default: out = 16'h0000;
        endcase
    end
endmodule

module rr_arb4x16 #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb4x16_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [4:0] BURST_LAST = 5'(BURST_LEN);
    localparam logic       HOLD_EN    = (BURST_LEN > 1) ? 1'b1 : 1'b0;

    state_t             state_r, state_nxt_s;
    logic [4:0]         beat_r, beat_nxt_s;
    logic [1:0]         last_r, last_nxt_s;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [1:0]         out_src_r;

    logic               load_s;
    logic               accept_s;
    logic [1:0]         src_s;
    logic               win_found_s;
    logic [1:0]         win_idx_s;
    logic [1:0]         cand_s;
    logic [WIDTH-1:0]   mux_word_s;

    assign load_s = ~out_valid_r | bus.out_ready;

    // Rotating-priority search starting just after the last granted requester.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last_r + 2'(k);
            if (!win_found_s && bus.in_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and grant decision; nothing moves while the output stage is stalled.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        last_nxt_s  = last_r;
        accept_s    = 1'b0;
        src_s       = last_r;
        if (load_s) begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        accept_s    = 1'b1;
                        src_s       = win_idx_s;
                        last_nxt_s  = win_idx_s;
                        beat_nxt_s  = 5'd1;
                        state_nxt_s = HOLD_EN ? HOLD : IDLE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HOLD: begin
                    if (bus.in_valid[last_r]) begin
                        accept_s = 1'b1;
                        src_s    = last_r;
                        if ((beat_r + 5'd1) == BURST_LAST) begin
                            beat_nxt_s  = 5'd0;
                            state_nxt_s = IDLE;
                        end else begin
                            beat_nxt_s  = beat_r + 5'd1;
                            state_nxt_s = HOLD;
                        end
                    end else if (win_found_s) begin
                        // Owner went quiet: hand over in the same cycle, no bubble.
                        accept_s    = 1'b1;
                        src_s       = win_idx_s;
                        last_nxt_s  = win_idx_s;
                        beat_nxt_s  = 5'd1;
                        state_nxt_s = HOLD_EN ? HOLD : IDLE;
                    end else begin
                        beat_nxt_s  = 5'd0;
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    beat_nxt_s  = 5'd0;
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Reset gating keeps in_ready low the instant rst_n drops.
    assign bus.in_ready = (accept_s && rst_n) ? (4'b0001 << src_s) : 4'b0000;

    mux4way16 u_mux (
        .in_data (bus.in_data),
        .sel     (src_s),
        .out     (mux_word_s)
    );

    // Arbitration state; last resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            beat_r  <= 5'd0;
            last_r  <= 2'd3;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Output stage: capture on accept, clear valid once consumed with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
            out_src_r   <= 2'd0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= mux_word_s;
            out_src_r   <= src_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
endmodule

// File: tb/tb_rr_arb4x16.sv
// Scoreboard bench: two arbiters (burst 4 and burst 1) share identical stimulus
// and are compared against a grant-level reference model.
module tb_rr_arb4x16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arb4x16_if ifa ();
    rr_arb4x16_if ifb ();

    rr_arb4x16 #(.WIDTH(16), .BURST_LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    rr_arb4x16 #(.WIDTH(16), .BURST_LEN(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    logic [3:0]  drv_valid = 4'b0000;
    logic [63:0] drv_data  = 64'h0;
    logic        drv_ready = 1'b0;

    assign ifa.in_valid  = drv_valid;
    assign ifa.in_data   = drv_data;
    assign ifa.out_ready = drv_ready;
    assign ifb.in_valid  = drv_valid;
    assign ifb.in_data   = drv_data;
    assign ifb.out_ready = drv_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state per arbiter: current owner, beats taken, burst lock.
    int  bl[2]      = '{4, 1};
    int  m_owner[2];
    int  m_beats[2];
    bit  m_busy[2];
    bit  m_ov[2];
    logic [17:0] qa[$];
    logic [17:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = 3;
            m_beats[d] = 0;
            m_busy[d]  = 1'b0;
            m_ov[d]    = 1'b0;
        end
        qa.delete();
        qb.delete();
    endtask

    // One cycle of the arbiter's contract, evaluated mid-cycle with inputs settled.
    task automatic model_step(input int d, input logic [3:0] dut_rdy, input logic dut_ov);
        logic [3:0] exp_rdy;
        int  src;
        bit  g;
        logic [15:0] word;
        exp_rdy = 4'b0000;
        src = 0;
        g = 1'b0;
        chk(d == 0 ? "a_out_valid" : "b_out_valid", 32'(dut_ov), 32'(m_ov[d]));
        if (!m_ov[d] || drv_ready) begin
            if (m_busy[d] && drv_valid[m_owner[d]]) begin
                g = 1'b1;
                src = m_owner[d];
                m_beats[d]++;
                if (m_beats[d] == bl[d]) m_busy[d] = 1'b0;
            end else begin
                m_busy[d] = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!g && drv_valid[(m_owner[d] + k) % 4]) begin
                        g = 1'b1;
                        src = (m_owner[d] + k) % 4;
                    end
                end
                if (g) begin
                    m_owner[d] = src;
                    m_beats[d] = 1;
                    m_busy[d]  = (bl[d] > 1);
                end
            end
            if (g) begin
                exp_rdy[src] = 1'b1;
                m_ov[d] = 1'b1;
                word = drv_data[16*src +: 16];
                if (d == 0) qa.push_back({2'(src), word});
                else        qb.push_back({2'(src), word});
            end else begin
                m_ov[d] = 1'b0;
            end
        end
        chk(d == 0 ? "a_in_ready" : "b_in_ready", 32'(dut_rdy), 32'(exp_rdy));
    endtask

    // Drive one cycle's inputs, run the model mid-cycle, return just after the edge.
    task automatic cycle(input logic [3:0] v, input logic [63:0] dat, input logic rdy);
        drv_valid = v;
        drv_data  = dat;
        drv_ready = rdy;
        @(negedge clk);
        model_step(0, ifa.in_ready, ifa.out_valid);
        model_step(1, ifb.in_ready, ifb.out_valid);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_out_data", 32'(ifa.out_data), 32'd0);
        chk("rst_out_src", 32'(ifa.out_src), 32'd0);
        rst_n = 1'b1;
    endtask

    // Monitor A: every consumed word must match the head of its scoreboard.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_word", 32'(ifa.out_data), 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                chk("a_data", 32'(ifa.out_data), 32'(e[15:0]));
                chk("a_src", 32'(ifa.out_src), 32'(e[17:16]));
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_word", 32'(ifb.out_data), 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                chk("b_data", 32'(ifb.out_data), 32'(e[15:0]));
                chk("b_src", 32'(ifb.out_src), 32'(e[17:16]));
            end
        end
    end

    initial begin
        logic [63:0] rnd;
        model_reset();
        do_reset();

        // Single request from requester 2.
        cycle(4'b0100, {16'h0000, 16'hBEEF, 16'h0000, 16'h0000}, 1'b1);
        chk("t1_out_valid", 32'(ifa.out_valid), 32'd1);
        chk("t1_out_data", 32'(ifa.out_data), 32'hBEEF);
        chk("t1_out_src", 32'(ifa.out_src), 32'd2);
        cycle(4'b0000, 64'h0, 1'b1);

        // All requesters valid: burst-4 grouping on A, plain rotation on B.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cycle(4'b1111, {16'h3000 + 16'(k), 16'h2000 + 16'(k), 16'h1000 + 16'(k), 16'(k)}, 1'b1);
            chk("t3_a_src", 32'(ifa.out_src), 32'(k / 4));
            chk("t2_b_src", 32'(ifb.out_src), 32'(k % 4));
            chk("t3_a_valid", 32'(ifa.out_valid), 32'd1);
        end

        // Backpressure holds the output word and blocks accepts.
        cycle(4'b1111, {4{16'h1234}}, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, {4{16'h5A5A}}, 1'b0);
            chk("t4_hold_data", 32'(ifa.out_data), 32'h1234);
            chk("t4_in_ready", 32'(ifa.in_ready), 32'd0);
        end
        cycle(4'b1111, {4{16'h5A5A}}, 1'b1);
        chk("t4_next_data", 32'(ifa.out_data), 32'h5A5A);
        cycle(4'b0000, 64'h0, 1'b1);

        // Owner 1 drops after two beats; requester 3 takes over with no bubble.
        do_reset();
        cycle(4'b1010, {16'hD003, 16'h0, 16'hD001, 16'h0}, 1'b1);
        cycle(4'b1010, {16'hD013, 16'h0, 16'hD011, 16'h0}, 1'b1);
        cycle(4'b1000, {16'hD023, 16'h0, 16'hD021, 16'h0}, 1'b1);
        chk("t5_src", 32'(ifa.out_src), 32'd3);
        chk("t5_valid", 32'(ifa.out_valid), 32'd1);
        cycle(4'b0000, 64'h0, 1'b1);

        // Asynchronous reset in the middle of a burst.
        cycle(4'b1111, {4{16'hC0DE}}, 1'b1);
        cycle(4'b1111, {4{16'hC0DF}}, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_a_valid_async", 32'(ifa.out_valid), 32'd0);
        chk("t6_a_ready_async", 32'(ifa.in_ready), 32'd0);
        chk("t6_b_ready_async", 32'(ifb.in_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(4'b1111, {16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00}, 1'b1);
        chk("t6_a_first_src", 32'(ifa.out_src), 32'd0);
        chk("t6_b_first_src", 32'(ifb.out_src), 32'd0);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 600; k++) begin
            rnd = {$urandom, $urandom};
            cycle(4'($urandom), rnd, ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm nothing is left outstanding.
        for (int k = 0; k < 3; k++) cycle(4'b0000, 64'h0, 1'b1);
        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
